// File: rtl/fm_ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fm_ram_pkg
//  Description : Shared types, per-role sizing defaults and the lane-packing
//                helper for the ping-pong feature-map buffers.
//  Revision    : 1.0 - initial release
// ============================================================================
package fm_ram_pkg;

   // Default geometry per buffer role (DATA_W / DEPTH / NPAR)
   localparam int C_IN_TILE_DATA_W  = 16;
   localparam int C_IN_TILE_DEPTH   = 1024;
   localparam int C_IN_TILE_NPAR    = 4;

   localparam int C_OUT_TILE_DATA_W = 16;
   localparam int C_OUT_TILE_DEPTH  = 1024;
   localparam int C_OUT_TILE_NPAR   = 4;

   localparam int C_EXP_KER_DATA_W  = 16;
   localparam int C_EXP_KER_DEPTH   = 512;
   localparam int C_EXP_KER_NPAR    = 8;

   localparam int C_PW_KER_DATA_W   = 16;
   localparam int C_PW_KER_DEPTH    = 512;
   localparam int C_PW_KER_NPAR     = 8;

   localparam int C_DW_KER_DATA_W   = 16;
   localparam int C_DW_KER_DEPTH    = 256;
   localparam int C_DW_KER_NPAR     = 4;

   localparam int C_INTER_DATA_W    = 16;
   localparam int C_INTER_DEPTH     = 2048;
   localparam int C_INTER_NPAR      = 4;

   // Bank ownership state: which banks hold data, which one DMA fills,
   // which one compute drains.
   typedef struct packed {
      logic [1:0] full;
      logic       wsel;
      logic       rsel;
   } bank_state_t;

   localparam bank_state_t C_BANK_STATE_RST = '{full: 2'b00, wsel: 1'b0, rsel: 1'b0};

   // LSB position of read lane 'lane' inside the packed rd_data bus
   function automatic int lane_lsb(input int lane, input int data_w);
      return lane * data_w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fm_sdp_bank.sv
`default_nettype none
// ============================================================================
//  Module      : fm_sdp_bank
//  Description : Simple dual-port synchronous RAM, one write port and one
//                registered read port. The read register holds its value
//                when no read is issued and clears on reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module fm_sdp_bank
   import fm_ram_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ROWS   = 256,
   parameter int RAW    = $clog2(ROWS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [RAW-1:0]    waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [RAW-1:0]    raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [ROWS];
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] rdata_d;

   // Storage array: written only, never reset
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // Read register keeps the last word until the next read
   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = mem_q[raddr];
      end
   end

   // Registered read port
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/fm_pingpong_ram.sv
`default_nettype none
// ============================================================================
//  Module      : fm_pingpong_ram
//  Description : Double-buffered feature-map / weight buffer. DMA fills one
//                bank word by word while compute drains the other bank NPAR
//                words per cycle; ownership swaps through done handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module fm_pingpong_ram
   import fm_ram_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 1024,
   parameter int NPAR   = 4,
   parameter int AW     = $clog2(DEPTH),
   parameter int RAW    = $clog2(DEPTH / NPAR)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [AW-1:0]            wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     wr_done,
   output logic                     wr_ready,
   input  logic                     rd_en,
   input  logic [RAW-1:0]           rd_addr,
   input  logic                     rd_done,
   input  logic                     rd_reuse,
   output logic                     rd_avail,
   output logic [NPAR*DATA_W-1:0]   rd_data,
   output logic                     rd_valid,
   output logic [1:0]               occupancy,
   output logic                     err
);

   localparam int          C_ROWS      = DEPTH / NPAR;
   localparam logic [AW:0] C_DEPTH_EXT = (AW + 1)'(DEPTH);

   bank_state_t state_q, state_d;
   logic        err_q, err_d;
   logic        rd_valid_q, rd_valid_d;
   logic        rd_bank_q, rd_bank_d;

   logic          w_wr_ready;
   logic          w_rd_avail;
   logic          w_addr_oob;
   logic          w_wr_acc;
   logic          w_rd_acc;
   logic          w_wr_done_acc;
   logic          w_rd_release;
   logic [AW-1:0] w_wr_lane;
   logic [AW-1:0] w_wr_row_full;
   logic [RAW-1:0] w_wr_row;

   logic [DATA_W-1:0] w_bank_rdata [2][NPAR];

   // Handshake qualifiers and write address split (lane = a%NPAR, row = a/NPAR)
   always_comb begin
      w_wr_ready    = !state_q.full[state_q.wsel];
      w_rd_avail    = state_q.full[state_q.rsel];
      w_addr_oob    = ({1'b0, wr_addr} >= C_DEPTH_EXT);
      w_wr_acc      = wr_en && w_wr_ready && !w_addr_oob;
      w_rd_acc      = rd_en && w_rd_avail;
      w_wr_done_acc = wr_done && w_wr_ready;
      w_rd_release  = rd_done && w_rd_avail && !rd_reuse;
      w_wr_lane     = wr_addr % AW'(NPAR);
      w_wr_row_full = wr_addr / AW'(NPAR);
      w_wr_row      = w_wr_row_full[RAW-1:0];
   end

   // Next-state: both done handshakes use pre-edge state; the full bit of
   // each bank is resolved on its own, so a simultaneous fill and release
   // never collide.
   always_comb begin
      state_d    = state_q;
      err_d      = err_q;
      rd_valid_d = w_rd_acc;
      rd_bank_d  = w_rd_acc ? state_q.rsel : rd_bank_q;

      if (w_wr_done_acc) begin
         state_d.full[state_q.wsel] = 1'b1;
         state_d.wsel               = ~state_q.wsel;
      end
      if (w_rd_release) begin
         state_d.full[state_q.rsel] = 1'b0;
         state_d.rsel               = ~state_q.rsel;
      end

      if ((wr_en && !w_wr_ready) || (wr_en && w_addr_oob) ||
          (rd_en && !w_rd_avail) || (wr_done && !w_wr_ready) ||
          (rd_done && !w_rd_avail)) begin
         err_d = 1'b1;
      end
   end

   // Control registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= C_BANK_STATE_RST;
         err_q      <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_bank_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         err_q      <= err_d;
         rd_valid_q <= rd_valid_d;
         rd_bank_q  <= rd_bank_d;
      end
   end

   // Two banks of NPAR sub-banks; a read touches every lane of bank rsel
   for (genvar b = 0; b < 2; b++) begin : g_bank
      for (genvar l = 0; l < NPAR; l++) begin : g_lane
         logic w_we;
         logic w_re;

         assign w_we = w_wr_acc && (state_q.wsel == 1'(b)) && (w_wr_lane == AW'(l));
         assign w_re = w_rd_acc && (state_q.rsel == 1'(b));

         fm_sdp_bank #(
            .DATA_W (DATA_W),
            .ROWS   (C_ROWS),
            .RAW    (RAW)
         ) u_sdp (
            .clk   (clk),
            .rst   (rst),
            .we    (w_we),
            .waddr (w_wr_row),
            .wdata (wr_data),
            .re    (w_re),
            .raddr (rd_addr),
            .rdata (w_bank_rdata[b][l])
         );
      end
   end

   // Output lanes follow the bank of the most recent accepted read
   for (genvar l = 0; l < NPAR; l++) begin : g_out
      assign rd_data[lane_lsb(l, DATA_W) +: DATA_W] =
         rd_bank_q ? w_bank_rdata[1][l] : w_bank_rdata[0][l];
   end

   assign wr_ready  = w_wr_ready;
   assign rd_avail  = w_rd_avail;
   assign occupancy = {1'b0, state_q.full[0]} + {1'b0, state_q.full[1]};
   assign rd_valid  = rd_valid_q;
   assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fm_pingpong_ram.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fm_pingpong_ram
//  Description : Directed self-checking bench for fm_pingpong_ram with a
//                read-data scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fm_pingpong_ram;

   localparam int DATA_W = 16;
   localparam int DEPTH  = 1024;
   localparam int NPAR   = 4;
   localparam int AW     = 10;
   localparam int RAW    = 8;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   wr_en;
   logic [AW-1:0]          wr_addr;
   logic [DATA_W-1:0]      wr_data;
   logic                   wr_done;
   logic                   wr_ready;
   logic                   rd_en;
   logic [RAW-1:0]         rd_addr;
   logic                   rd_done;
   logic                   rd_reuse;
   logic                   rd_avail;
   logic [NPAR*DATA_W-1:0] rd_data;
   logic                   rd_valid;
   logic [1:0]             occupancy;
   logic                   err;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DATA_W-1:0]      mem [2][DEPTH];
   logic [63:0]            sb [$];
   logic                   pend_rv = 1'b0;
   logic [63:0]            last_data = '0;

   always #5 clk = ~clk;

   fm_pingpong_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .NPAR   (NPAR)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_done   (wr_done),
      .wr_ready  (wr_ready),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_done   (rd_done),
      .rd_reuse  (rd_reuse),
      .rd_avail  (rd_avail),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .occupancy (occupancy),
      .err       (err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_flags(input string tag, input logic e_wr_ready, input logic e_rd_avail,
                            input logic [1:0] e_occ, input logic e_err);
      chk({tag, ".wr_ready"},  64'(wr_ready),  64'(e_wr_ready));
      chk({tag, ".rd_avail"},  64'(rd_avail),  64'(e_rd_avail));
      chk({tag, ".occupancy"}, 64'(occupancy), 64'(e_occ));
      chk({tag, ".err"},       64'(err),       64'(e_err));
   endtask

   // Advance one clock; check rd_valid/rd_data against the scoreboard
   // #1 after the edge, then drop all single-cycle strobes.
   task automatic tick();
      logic        rst_s;
      logic        exp_rv;
      logic [63:0] e;
      rst_s   = rst;
      exp_rv  = pend_rv && !rst_s;
      pend_rv = 1'b0;
      @(posedge clk);
      #1;
      if (rst_s) begin
         sb.delete();
         last_data = '0;
      end
      chk("rd_valid", 64'(rd_valid), 64'(exp_rv));
      if (exp_rv) begin
         chk("sb_nonempty", 64'(sb.size() > 0), 64'(1));
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rd_data", rd_data, e);
            last_data = e;
         end
      end else begin
         chk("rd_data_hold", rd_data, last_data);
      end
      wr_en    = 1'b0;
      wr_done  = 1'b0;
      rd_en    = 1'b0;
      rd_done  = 1'b0;
      rd_reuse = 1'b0;
   endtask

   task automatic wr(input int bank, input int addr, input logic [15:0] data, input logic ok);
      wr_en   = 1'b1;
      wr_addr = AW'(addr);
      wr_data = data;
      if (ok) mem[bank][addr] = data;
   endtask

   task automatic rd(input int bank, input int grp);
      logic [63:0] e;
      rd_en   = 1'b1;
      rd_addr = RAW'(grp);
      for (int i = 0; i < NPAR; i++) e[i*16 +: 16] = mem[bank][grp*NPAR + i];
      sb.push_back(e);
      pend_rv = 1'b1;
   endtask

   // Watchdog against a stuck run
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_done = 1'b0;
      rd_en = 1'b0; rd_addr = '0; rd_done = 1'b0; rd_reuse = 1'b0;

      // Reset state
      repeat (3) tick();
      chk_flags("reset", 1'b1, 1'b0, 2'd0, 1'b0);
      rst = 1'b0;
      tick();

      // Read with nothing available: dropped, err sticky
      rd_en = 1'b1; rd_addr = '0;
      tick();
      chk("rd_unavail.err", 64'(err), 64'(1));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_flags("reset2", 1'b1, 1'b0, 2'd0, 1'b0);

      // Fill bank 0 with address values, hand it over
      for (int a = 0; a < DEPTH; a++) begin
         wr(0, a, 16'(a), 1'b1);
         tick();
      end
      wr_done = 1'b1;
      tick();
      chk_flags("fill0", 1'b1, 1'b1, 2'd1, 1'b0);

      // Group 5 -> lanes 20,21,22,23; then rd_data must hold
      rd(0, 5);
      tick();
      tick();

      // Overlap: fill bank 1 while draining bank 0
      for (int a = 0; a < DEPTH; a++) begin
         wr(1, a, 16'(a + 16'h1000), 1'b1);
         rd(0, a % (DEPTH / NPAR));
         tick();
      end
      wr_done = 1'b1;
      tick();
      chk_flags("both_full", 1'b0, 1'b1, 2'd2, 1'b0);

      // Write while both banks full: dropped, err set
      wr(0, 7, 16'hdead, 1'b0);
      tick();
      chk_flags("drop_wr", 1'b0, 1'b1, 2'd2, 1'b1);

      // Release bank 0, bank 1 now drains
      rd_done = 1'b1;
      tick();
      chk_flags("release0", 1'b1, 1'b1, 2'd1, 1'b1);
      rd(1, 0);
      tick();

      // Reuse bank 1 three times; data stays readable
      for (int k = 0; k < 3; k++) begin
         rd_done = 1'b1; rd_reuse = 1'b1;
         tick();
         chk("reuse.rd_avail", 64'(rd_avail), 64'(1));
         chk("reuse.occupancy", 64'(occupancy), 64'(1));
         rd(1, 3);
         tick();
      end

      // Refill bank 0; last write lands in the same cycle as wr_done while
      // bank 1 is released: occupancy stays 1, both selects toggle.
      for (int a = 0; a < 7; a++) begin
         wr(0, a, 16'(a + 16'h2000), 1'b1);
         tick();
      end
      wr(0, 7, 16'h2007, 1'b1);
      wr_done = 1'b1; rd_done = 1'b1; rd_reuse = 1'b0;
      tick();
      chk_flags("swap", 1'b1, 1'b1, 2'd1, 1'b1);
      rd(0, 1);
      tick();
      rd(0, 5);
      tick();

      // Reset in the cycle after a read, and with a read in flight
      rd(0, 0);
      tick();
      rd(0, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_flags("rst_mid", 1'b1, 1'b0, 2'd0, 1'b0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
